// File: rtl/utmi_rx_path.sv
// utmi_rx_path: USB FS receive path, 4x oversampled line to bytes with UTMI RX handshake.
// Bit timing is fixed at four Clk per bit; the phase counter resyncs on every line change.
module utmi_rx_path #(
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX_en,
  input  logic       RX_DP,
  input  logic       RX_DM,
  output logic [7:0] DataOut,
  output logic       RX_Valid,
  output logic       RX_Active,
  output logic       RX_Error
);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;
  localparam logic [2:0] ZMIN = SYNC_MIN_ZEROS[2:0];
  state_t st_q, st_d;
  logic [1:0] line_q, phase_q, phase_d, ph;
  logic [2:0] cnt_q, cnt_d, ones_q, ones_d, bit_q, bit_d;
  logic [7:0] sr_q, sr_d, data_q, data_d;
  logic prev_q, prev_d, se0_q, se0_d, valid_q, valid_d, err_q, err_d, active_q, active_d;
  logic smp, is_j, is_k, is_se0, jk, b;
  always_comb begin
    ph = (line_q != {RX_DP, RX_DM}) ? 2'd0 : phase_q + 2'd1;
    smp = RX_en && ph == 2'd2;
    is_j = {RX_DP, RX_DM} == 2'b10;
    is_k = {RX_DP, RX_DM} == 2'b01;
    is_se0 = {RX_DP, RX_DM} == 2'b00;
    jk = is_j || is_k;
    b = RX_DP == prev_q;
    st_d = st_q;
    cnt_d = cnt_q;
    ones_d = ones_q;
    bit_d = bit_q;
    se0_d = se0_q;
    sr_d = sr_q;
    data_d = data_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    prev_d = (smp && jk) ? RX_DP : prev_q;
    phase_d = RX_en ? ph : 2'd0;
    if (smp) begin
      case (st_q)
        IDLE: if (is_k) begin
          st_d = SYNC;
          cnt_d = 3'd0;
        end
        SYNC:
          if (!jk) st_d = IDLE;
          else if (!b) cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
          else if (cnt_q >= ZMIN) begin
            st_d = DATA;
            ones_d = 3'd0;
            bit_d = 3'd0;
          end else st_d = IDLE;
        DATA:
          if (is_se0 && bit_q == 3'd0) begin
            st_d = EOP;
            cnt_d = 3'd1;
          end else if (!jk || (ones_q == 3'd6 && b)) begin
            st_d = ABORT;
            err_d = 1'b1;
            cnt_d = 3'd0;
            se0_d = is_se0;
          end else if (ones_q == 3'd6) ones_d = 3'd0;
          else begin
            ones_d = b ? ones_q + 3'd1 : 3'd0;
            sr_d = {b, sr_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              data_d = {b, sr_q[7:1]};
              valid_d = 1'b1;
            end
          end
        EOP:
          if (is_j) st_d = IDLE;
          else if (is_se0 && cnt_q != 3'd3) cnt_d = cnt_q + 3'd1;
          else begin
            st_d = ABORT;
            err_d = 1'b1;
            cnt_d = 3'd0;
            se0_d = is_se0;
          end
        ABORT: begin
          // leave on J right after SE0, or on the eighth J in a row
          se0_d = is_se0;
          cnt_d = is_j ? cnt_q + 3'd1 : 3'd0;
          if (is_j && (se0_q || cnt_q == 3'd7)) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
    if (!RX_en) begin
      st_d = IDLE;
      ones_d = 3'd0;
      bit_d = 3'd0;
      prev_d = 1'b1;
      data_d = 8'd0;
      valid_d = 1'b0;
      err_d = 1'b0;
    end
    active_d = st_d == DATA || st_d == EOP || st_d == ABORT;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st_q <= IDLE;
      line_q <= 2'b10;
      phase_q <= 2'd0;
      cnt_q <= 3'd0;
      ones_q <= 3'd0;
      bit_q <= 3'd0;
      sr_q <= 8'd0;
      data_q <= 8'd0;
      prev_q <= 1'b1;
      se0_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      st_q <= st_d;
      line_q <= {RX_DP, RX_DM};
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      data_q <= data_d;
      prev_q <= prev_d;
      se0_q <= se0_d;
      valid_q <= valid_d;
      err_q <= err_d;
      active_q <= active_d;
    end
  end
  assign DataOut = data_q;
  assign RX_Valid = valid_q;
  assign RX_Active = active_q;
  assign RX_Error = err_q;
endmodule

// File: doc/utmi_rx_path.md
Name: utmi_rx_path

Overview:
- Receive half of the UTMI serial engine. Pairs with the transmit path on the same USB FS line.
- Oversamples the differential line at 4x bit rate, recovers bit timing, and detects SYNC.
- NRZI-decodes, removes stuffed bits, detects EOP and deserializes LSB-first into bytes.
- Presents bytes to the link layer with the UTMI RX_Active / RX_Valid / RX_Error handshake.

Parameters:
- OVERSAMPLE, 4: Clk cycles per bit time. Fixed at 4; the phase counter is 2 bits.
- SYNC_MIN_ZEROS, 5: minimum decoded 0s before the terminating 1 for SYNC to be accepted.

Ports:
- Clk  in  1  bit-rate x4 clock
- Rst  in  1  asynchronous, active-high reset
- RX_en  in  1  receiver enable; low while the transmitter owns the line
- RX_DP  in  1  D+ line, already synchronized to Clk
- RX_DM  in  1  D- line, already synchronized to Clk
- DataOut  out  8  received byte; valid when RX_Valid=1
- RX_Valid  out  1  one-cycle pulse per completed byte
- RX_Active  out  1  high from SYNC accept until EOP/abort completes
- RX_Error  out  1  one-cycle pulse on stuff, SE1, partial-byte or bad-EOP error

Behaviour:
- Reset values:
  - DataOut=0, RX_Valid=0, RX_Active=0, RX_Error=0.
  - FSM=IDLE, phase=0, prev_state=J, ones_cnt=0, bit_cnt=0.
- Line state decode: J={1,0}, K={0,1}, SE0={0,0}, SE1={1,1}.
- Phase counter (2-bit):
  - Clears to 0 on any change of {RX_DP,RX_DM} from the previous Clk sample; otherwise increments with 3->0 wrap.
  - A bit is sampled when phase==2, i.e. mid-bit. Exactly one sample per bit; stretched or shortened bits are tracked.
- NRZI decode on each sample: bit=1 if the sampled J/K equals prev_state, else 0. prev_state updates on every J/K sample.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
- IDLE:
  - On the first K sample, go to SYNC; clear the zero counter.
  - SE0/SE1 samples are ignored.
- SYNC:
  - Count decoded 0s.
  - A decoded 1 with zeros>=SYNC_MIN_ZEROS goes to DATA; RX_Active rises the next Clk and bit_cnt=0, ones_cnt=0.
  - A decoded 1 with fewer zeros, or an SE0/SE1 sample, returns to IDLE silently.
- DATA:
  - ones_cnt increments on decoded 1 and clears on 0.
  - When ones_cnt==6, the next bit must be 0 and is dropped, not shifted. If it is 1, pulse RX_Error and go to ABORT.
  - Non-stuff bits shift into an 8-bit register from the MSB end, so bits arrive LSB-first.
  - On the 8th bit, load DataOut and pulse RX_Valid on the Clk after that sample; bit_cnt wraps to 0.
  - SE0 sample: if bit_cnt==0, go to EOP; otherwise pulse RX_Error and go to ABORT.
  - SE1 sample: pulse RX_Error and go to ABORT.
- EOP:
  - Count SE0 samples, starting at 1.
  - A J sample with SE0 count of 1..3 goes to IDLE; RX_Active falls the next Clk and no error is raised.
  - A K or SE1 sample, or a 4th SE0 sample, pulses RX_Error and goes to ABORT.
- ABORT:
  - RX_Active stays high. No RX_Valid is generated.
  - Exit to IDLE on a J sample following an SE0, or on 8 consecutive J samples. RX_Active falls on exit.
- Error pulses: RX_Error is a single Clk pulse on entry to ABORT and never coincides with RX_Valid. A stuff error on the 8th bit suppresses that byte.
- RX_en:
  - RX_en=0 forces IDLE on the next Clk and clears the phase, ones and bit counters. prev_state returns to J.
  - RX_Active drops and no RX_Error is raised. The RX_Valid pulse in progress completes.
- Rst mid-packet: all state returns to the reset values asynchronously and no partial byte is emitted.

Test Plan:
- Packet SYNC(KJKJKJKK) + 0xA5 + SE0,SE0,J at 4 Clk/bit -> RX_Active rises after the last SYNC K; one RX_Valid with DataOut=0xA5; RX_Active falls 1 Clk after the J sample; RX_Error never asserts.
- SYNC + 0x3F,0xFF (stuffed bits inserted by the bench) + EOP -> RX_Valid twice with DataOut=0x3F then 0xFF; stuffed 0s are discarded; no error.
- SYNC then seven consecutive decoded 1s -> RX_Error pulses once after the 7th-bit sample; no RX_Valid; RX_Active stays high until SE0,J, then falls.
- SYNC + 4 data bits + SE0 -> RX_Error pulses once, no RX_Valid, recovery to IDLE after J.
- 0x5A packet with one bit stretched to 5 Clk and another shortened to 3 Clk -> DataOut=0x5A, no error; the phase counter resynchronizes on the edges.
- Rst asserted mid-byte, or RX_en dropped mid-byte, of a 0xC3 packet -> outputs go to reset values; no RX_Valid or RX_Error; the next full packet with 0x11 is received correctly.
